// File: rtl/bg_mask_compositor.sv
// Final stage of the background-removal pipe. Reads the RGB and mask line buffers in lockstep
// and outputs each pixel, or the background colour where the mask bit is 0, as a valid/ready stream.
module bg_mask_compositor #(
   parameter int DATA_WIDTH = 24,
   parameter int LINE_WIDTH = 640,
   parameter int CNT_W      = 16
) (
   input  logic                  i_CLK,
   input  logic                  i_RST,
   input  logic                  i_RGB_INTR,
   input  logic                  i_MASK_INTR,
   output logic                  o_RGB_READ,
   output logic                  o_MASK_READ,
   input  logic [DATA_WIDTH-1:0] i_RGB_DATA,
   input  logic                  i_MASK_DATA,
   input  logic [DATA_WIDTH-1:0] i_BG_COLOR,
   output logic [DATA_WIDTH-1:0] o_DATA,
   output logic                  o_VALID,
   input  logic                  i_READY,
   output logic                  o_LINE_DONE,
   output logic [CNT_W-1:0]      o_LINE_CNT
);

   localparam int RC_W = $clog2(LINE_WIDTH + 1);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [RC_W-1:0]       rdCnt_q, rdCnt_d;
   logic [CNT_W-1:0]      lineCnt_q, lineCnt_d;
   logic                  inflight_q;
   logic [DATA_WIDTH-1:0] fifoMem_q [2];
   logic                  wrPtr_q, rdPtr_q;
   logic [1:0]            fifoCnt_q;

   logic                  pop, push, issue, lastPop;
   logic [2:0]            occupancy;
   logic [DATA_WIDTH-1:0] composed;

   // Credit check counts the word still in flight so a returned word always finds a free slot.
   assign pop       = (fifoCnt_q != 2'd0) && i_READY;
   assign push      = inflight_q;
   assign occupancy = {1'b0, fifoCnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue     = (state_q == READ) && (rdCnt_q < RC_W'(LINE_WIDTH)) && (occupancy < 3'd2);
   assign lastPop   = (state_q == DRAIN) && pop && (fifoCnt_q == 2'd1) && !inflight_q;
   assign composed  = i_MASK_DATA ? i_RGB_DATA : i_BG_COLOR;

   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         state_q   <= IDLE;
         rdCnt_q   <= '0;
         lineCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rdCnt_q   <= rdCnt_d;
         lineCnt_q <= lineCnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rdCnt_d   = rdCnt_q;
      lineCnt_d = lineCnt_q;
      case (state_q)
         IDLE: begin
            rdCnt_d = '0;
            if (i_RGB_INTR && i_MASK_INTR) begin
               state_d = READ;
            end
         end
         READ: begin
            if (issue) begin
               rdCnt_d = rdCnt_q + RC_W'(1);
               if (rdCnt_q == RC_W'(LINE_WIDTH - 1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (lastPop) begin
               state_d   = IDLE;
               lineCnt_d = lineCnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_RGB_READ  = issue;
      o_MASK_READ = issue;
      o_LINE_DONE = lastPop;
      o_LINE_CNT  = lineCnt_q;
   end

   // Two-entry output FIFO; the head is presented directly on the stream.
   always_ff @(posedge i_CLK or posedge i_RST) begin
      if (i_RST) begin
         inflight_q <= 1'b0;
         wrPtr_q    <= 1'b0;
         rdPtr_q    <= 1'b0;
         fifoCnt_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            fifoMem_q[i] <= '0;
         end
      end else begin
         inflight_q <= issue;
         if (push) begin
            fifoMem_q[wrPtr_q] <= composed;
            wrPtr_q            <= ~wrPtr_q;
         end
         if (pop) begin
            rdPtr_q <= ~rdPtr_q;
         end
         fifoCnt_q <= fifoCnt_q + {1'b0, push} - {1'b0, pop};
      end
   end

   assign o_DATA  = fifoMem_q[rdPtr_q];
   assign o_VALID = (fifoCnt_q != 2'd0);

endmodule
